// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic feeder.
// FSM encoding and operand lane-packing indices.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_FEED,
      ST_WAIT,
      ST_HOLD
   } state_t;

   // Element positions inside a packed {x00,x01,x10,x11} word
   localparam int unsigned IDX_00 = 3;
   localparam int unsigned IDX_01 = 2;
   localparam int unsigned IDX_10 = 1;
   localparam int unsigned IDX_11 = 0;

   // Feed phases
   localparam logic [1:0] PH_0 = 2'd0;
   localparam logic [1:0] PH_1 = 2'd1;
   localparam logic [1:0] PH_2 = 2'd2;

endpackage

// File: rtl/systolic_feeder_2x2.sv
// Operand skewing feeder and result holder for a 2x2 systolic array.
// Accepts A/B, pulses arr_en, skews lanes over 3 cycles, captures arr_out.
module systolic_feeder_2x2
   import systolic_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*WIDTH-1:0] in_a,
   input  logic [4*WIDTH-1:0] in_b,
   output logic               arr_en,
   output logic [WIDTH-1:0]   arr_north0,
   output logic [WIDTH-1:0]   arr_north1,
   output logic [WIDTH-1:0]   arr_west0,
   output logic [WIDTH-1:0]   arr_west2,
   input  logic               arr_done,
   input  logic [4*WIDTH-1:0] arr_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*WIDTH-1:0] out_c,
   output logic               err
);

   // Fractional bits must leave room for at least a sign bit
   if (FRAC_WIDTH >= WIDTH) begin : g_bad_frac
      $error("FRAC_WIDTH must be smaller than WIDTH");
   end

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   state_t             state;
   logic [1:0]         phase;
   logic [CW-1:0]      wait_cnt;
   logic [4*WIDTH-1:0] a_q;
   logic [4*WIDTH-1:0] b_q;

   logic [WIDTH-1:0] a00, a01, a10, a11;
   logic [WIDTH-1:0] b00, b01, b10, b11;

   assign a00 = a_q[IDX_00*WIDTH +: WIDTH];
   assign a01 = a_q[IDX_01*WIDTH +: WIDTH];
   assign a10 = a_q[IDX_10*WIDTH +: WIDTH];
   assign a11 = a_q[IDX_11*WIDTH +: WIDTH];
   assign b00 = b_q[IDX_00*WIDTH +: WIDTH];
   assign b01 = b_q[IDX_01*WIDTH +: WIDTH];
   assign b10 = b_q[IDX_10*WIDTH +: WIDTH];
   assign b11 = b_q[IDX_11*WIDTH +: WIDTH];

   assign in_ready = (state == ST_IDLE);

   // Main FSM: lanes, arr_en, result and err are all registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         phase      <= PH_0;
         wait_cnt   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         arr_en     <= 1'b0;
         arr_west0  <= '0;
         arr_west2  <= '0;
         arr_north0 <= '0;
         arr_north1 <= '0;
         out_valid  <= 1'b0;
         out_c      <= '0;
         err        <= 1'b0;
      end else begin
         arr_en     <= 1'b0;
         arr_west0  <= '0;
         arr_west2  <= '0;
         arr_north0 <= '0;
         arr_north1 <= '0;
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q    <= in_a;
                  b_q    <= in_b;
                  err    <= 1'b0;
                  arr_en <= 1'b1;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               phase      <= PH_0;
               arr_west0  <= a00;
               arr_north0 <= b00;
               state      <= ST_FEED;
            end
            ST_FEED: begin
               if (arr_done) begin
                  out_c     <= arr_out;
                  out_valid <= 1'b1;
                  phase     <= PH_0;
                  state     <= ST_HOLD;
               end else begin
                  unique case (phase)
                     PH_0: begin
                        arr_west0  <= a01;
                        arr_west2  <= a10;
                        arr_north0 <= b10;
                        arr_north1 <= b01;
                        phase      <= PH_1;
                     end
                     PH_1: begin
                        arr_west2  <= a11;
                        arr_north1 <= b11;
                        phase      <= PH_2;
                     end
                     default: begin
                        phase    <= PH_0;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                     end
                  endcase
               end
            end
            ST_WAIT: begin
               if (arr_done) begin
                  out_c     <= arr_out;
                  out_valid <= 1'b1;
                  wait_cnt  <= '0;
                  state     <= ST_HOLD;
               end else if (wait_cnt == WAIT_LAST) begin
                  err      <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 with a behavioural 2x2 array model.
// Q8.8 output-stationary array; done raised once the last product is in flight.
module tb_systolic_feeder_2x2;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [4*W-1:0] in_a;
   logic [4*W-1:0] in_b;
   logic           arr_en;
   logic [W-1:0]   arr_north0;
   logic [W-1:0]   arr_north1;
   logic [W-1:0]   arr_west0;
   logic [W-1:0]   arr_west2;
   logic           arr_done;
   logic [4*W-1:0] arr_out;
   logic           out_valid;
   logic           out_ready;
   logic [4*W-1:0] out_c;
   logic           err;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt   = 0;
   int en_base  = 0;

   systolic_feeder_2x2 #(
      .WIDTH(16),
      .FRAC_WIDTH(8),
      .TIMEOUT(15)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .arr_en(arr_en),
      .arr_north0(arr_north0),
      .arr_north1(arr_north1),
      .arr_west0(arr_west0),
      .arr_west2(arr_west2),
      .arr_done(arr_done),
      .arr_out(arr_out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_c(out_c),
      .err(err)
   );

   always #5 clk = ~clk;

   // ---------------- array model ----------------
   logic         done_en = 1'b0;
   int           step = 7;
   logic [W-1:0] ah00 = '0, ah10 = '0;
   logic [W-1:0] bv00 = '0, bv01 = '0;
   logic [W-1:0] acc00 = '0, acc01 = '0, acc10 = '0, acc11 = '0;
   logic [W-1:0] pend;

   function automatic logic [W-1:0] fmul(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic signed [31:0] p;
      p = $signed(a) * $signed(b);
      return p[23:8];
   endfunction

   assign pend     = fmul(ah10, bv01);
   assign arr_done = done_en && (step >= 3);
   assign arr_out  = {acc00, acc01, acc10, acc11 + pend};

   // PE grid: a flows east, b flows south, each PE accumulates a*b
   always @(posedge clk) begin
      if (arr_en) begin
         step  <= 0;
         ah00  <= '0;
         ah10  <= '0;
         bv00  <= '0;
         bv01  <= '0;
         acc00 <= '0;
         acc01 <= '0;
         acc10 <= '0;
         acc11 <= '0;
      end else begin
         acc00 <= acc00 + fmul(arr_west0, arr_north0);
         acc01 <= acc01 + fmul(ah00, arr_north1);
         acc10 <= acc10 + fmul(arr_west2, bv00);
         acc11 <= acc11 + fmul(ah10, bv01);
         ah00  <= arr_west0;
         ah10  <= arr_west2;
         bv00  <= arr_north0;
         bv01  <= arr_north1;
         if (step < 7) step <= step + 1;
      end
   end

   // Count start pulses seen by the array
   always @(posedge clk) begin
      if (rst_n && arr_en) en_cnt <= en_cnt + 1;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic lanes(input string tag,
                        input logic [W-1:0] w0, input logic [W-1:0] w2,
                        input logic [W-1:0] n0, input logic [W-1:0] n1);
      check({tag, ".west0"}, 64'(arr_west0), 64'(w0));
      check({tag, ".west2"}, 64'(arr_west2), 64'(w2));
      check({tag, ".north0"}, 64'(arr_north0), 64'(n0));
      check({tag, ".north1"}, 64'(arr_north1), 64'(n1));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [4*W-1:0] A1 = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
   localparam logic [4*W-1:0] B1 = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
   localparam logic [4*W-1:0] C1 = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
   localparam logic [4*W-1:0] A2 = {16'hFF00, 16'h0080, 16'hFE00, 16'h0100};
   localparam logic [4*W-1:0] B2 = {16'h0200, 16'h0100, 16'hFF00, 16'h0080};
   localparam logic [4*W-1:0] C2 = {16'hFD80, 16'hFF40, 16'hFB00, 16'hFE80};

   // ---------------- directed sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      @(negedge clk);
      check("rst.in_ready", 64'(in_ready), 64'd1);
      check("rst.arr_en", 64'(arr_en), 64'd0);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.out_c", out_c, 64'd0);
      check("rst.err", 64'(err), 64'd0);
      lanes("rst", 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic transaction with 10-cycle backpressure
      done_en  = 1'b1;
      in_a     = A1;
      in_b     = B1;
      in_valid = 1'b1;
      check("t1.in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("t1.start.en", 64'(arr_en), 64'd1);
      check("t1.start.rdy", 64'(in_ready), 64'd0);
      lanes("t1.start", 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      check("t1.p0.en", 64'(arr_en), 64'd0);
      lanes("t1.p0", 16'h0100, 16'h0000, 16'h0100, 16'h0000);
      tick();
      lanes("t1.p1", 16'h0200, 16'h0300, 16'h0000, 16'h0000);
      tick();
      lanes("t1.p2", 16'h0000, 16'h0400, 16'h0000, 16'h0100);
      tick();
      lanes("t1.wait", 16'h0, 16'h0, 16'h0, 16'h0);
      check("t1.wait.ov", 64'(out_valid), 64'd0);
      tick();
      check("t1.lat.ov", 64'(out_valid), 64'd1);
      check("t1.out_c", out_c, C1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t1.hold.ov", 64'(out_valid), 64'd1);
         check("t1.hold.c", out_c, C1);
         check("t1.hold.rdy", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1.rel.ov", 64'(out_valid), 64'd0);
      check("t1.rel.rdy", 64'(in_ready), 64'd1);

      // Timeout: array never completes
      done_en  = 1'b0;
      in_a     = A2;
      in_b     = B2;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (18) tick();
      check("to.pre.err", 64'(err), 64'd0);
      check("to.pre.rdy", 64'(in_ready), 64'd0);
      tick();
      check("to.err", 64'(err), 64'd1);
      check("to.rdy", 64'(in_ready), 64'd1);
      check("to.ov", 64'(out_valid), 64'd0);
      check("to.out_c", out_c, C1);
      tick();
      check("to.sticky", 64'(err), 64'd1);

      // Negative operands, consumer always ready; accept clears err
      done_en   = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      check("neg.err_clr", 64'(err), 64'd0);
      tick();
      lanes("neg.p0", 16'hFF00, 16'h0000, 16'h0200, 16'h0000);
      tick();
      lanes("neg.p1", 16'h0080, 16'hFE00, 16'hFF00, 16'h0100);
      tick();
      lanes("neg.p2", 16'h0000, 16'h0100, 16'h0000, 16'h0080);
      tick();
      tick();
      check("neg.ov", 64'(out_valid), 64'd1);
      check("neg.out_c", out_c, C2);
      tick();
      check("neg.rel.ov", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Asynchronous reset during FEED phase 1
      in_a     = A1;
      in_b     = B1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      lanes("ar.p1", 16'h0200, 16'h0300, 16'h0000, 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      lanes("ar.async", 16'h0, 16'h0, 16'h0, 16'h0);
      check("ar.rdy", 64'(in_ready), 64'd1);
      check("ar.out_c", out_c, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("ar.rel.rdy", 64'(in_ready), 64'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("ar.no_ov", 64'(out_valid), 64'd0);
      end

      // Back-to-back with in_valid held high
      en_base  = en_cnt;
      in_valid = 1'b1;
      tick();
      repeat (5) tick();
      check("bb.ov1", 64'(out_valid), 64'd1);
      check("bb.c1", out_c, C1);
      repeat (3) tick();
      check("bb.blk.rdy", 64'(in_ready), 64'd0);
      check("bb.blk.en", 64'(en_cnt - en_base), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bb.idle.rdy", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("bb.en2", 64'(arr_en), 64'd1);
      repeat (5) tick();
      check("bb.ov2", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (3) tick();
      check("bb.en_cnt", 64'(en_cnt - en_base), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
